fir_result_packer: RTL and testbench

- Sits directly downstream of the transposed FIR filter and consumes its 32-bit result and write-enable.
- Rounds and saturates each result to a 16-bit sample, then buffers it in an internal synchronous FIFO.
- Serialises each sample as two bytes, MSB first, on a valid/ready byte stream that feeds the UART/host transmitter.
- Keeps a sticky overflow flag for samples dropped when the FIFO is full.

---
 rtl/fir_result_packer.sv | 196 +++++++++++++++++++
 tb/tb_fir_result_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_result_packer.sv
// Rounds/saturates FIR results to 16-bit samples, queues them in a FIFO and
// streams each sample as two bytes (MSB first) on a valid/ready byte interface.
module fir_result_packer #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [IN_WIDTH-1:0]   i_fir_data,
    input  logic                  i_fir_wren,
    output logic [7:0]            o_byte,
    output logic                  o_byte_valid,
    input  logic                  i_byte_ready,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

    localparam logic signed [IN_WIDTH:0] L_ROUND = (IN_WIDTH+1)'(1'b1) << (SHIFT-1);
    localparam logic signed [IN_WIDTH:0] L_MAX   = (IN_WIDTH+1)'(32'sd32767);
    localparam logic signed [IN_WIDTH:0] L_MIN   = (IN_WIDTH+1)'(-32'sd32768);
    localparam logic [ADDR_WIDTH:0]      L_DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);

    // Round half-up on one extra bit of headroom, then clamp to the 16-bit range.
    function automatic logic [OUT_WIDTH-1:0] quantise(input logic [IN_WIDTH-1:0] d);
        logic signed [IN_WIDTH:0] sum;
        logic signed [IN_WIDTH:0] q;
        sum = $signed({d[IN_WIDTH-1], d}) + L_ROUND;
        q   = sum >>> SHIFT;
        if (q > L_MAX) begin
            quantise = L_MAX[OUT_WIDTH-1:0];
        end else if (q < L_MIN) begin
            quantise = L_MIN[OUT_WIDTH-1:0];
        end else begin
            quantise = q[OUT_WIDTH-1:0];
        end
    endfunction

    logic                  r_q_valid;
    logic [OUT_WIDTH-1:0]  r_q_data;
    logic [OUT_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_overflow;
    state_t                r_state;
    logic [OUT_WIDTH-1:0]  r_hold;
    logic [7:0]            r_byte;
    logic                  r_byte_valid;

    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_drop;
    logic                  w_accept;
    logic [OUT_WIDTH-1:0]  w_rd_word;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    state_t                w_state_nxt;
    logic [7:0]            w_byte_nxt;
    logic                  w_valid_nxt;

    assign w_pop     = (r_state == S_IDLE) && (r_count != (ADDR_WIDTH+1)'(0));
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign w_push_ok = r_q_valid && ((r_count != L_DEPTH) || w_pop);
    assign w_drop    = r_q_valid && !w_push_ok;
    assign w_accept  = r_byte_valid && i_byte_ready;
    assign w_rd_word = r_mem[r_rd_ptr];

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_count      = r_count;
    assign o_full       = r_full;
    assign o_overflow   = r_overflow;

    // Quantiser stage register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q_valid <= 1'b0;
            r_q_data  <= {OUT_WIDTH{1'b0}};
        end else begin
            r_q_valid <= i_fir_wren;
            if (i_fir_wren) begin
                r_q_data <= quantise(i_fir_data);
            end
        end
    end

    // FIFO storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_q_data;
        end
    end

    // Next FIFO occupancy from the push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
            2'b01:   w_count_nxt = r_count - (ADDR_WIDTH+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO pointers, occupancy, full and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= {ADDR_WIDTH{1'b0}};
            r_rd_ptr   <= {ADDR_WIDTH{1'b0}};
            r_count    <= {(ADDR_WIDTH+1){1'b0}};
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == L_DEPTH);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Serializer next state and next registered byte outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        w_valid_nxt = r_byte_valid;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_HI;
                    w_byte_nxt  = w_rd_word[15:8];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_byte_nxt  = 8'h00;
                    w_valid_nxt = 1'b0;
                end
            end
            S_HI: begin
                if (w_accept) begin
                    w_state_nxt = S_LO;
                    w_byte_nxt  = r_hold[7:0];
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_HI;
                end
            end
            S_LO: begin
                if (w_accept) begin
                    w_state_nxt = S_IDLE;
                    w_byte_nxt  = 8'h00;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_LO;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_byte_nxt  = 8'h00;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Serializer state, hold word and output byte registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_hold       <= {OUT_WIDTH{1'b0}};
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte       <= w_byte_nxt;
            r_byte_valid <= w_valid_nxt;
            if (w_pop) begin
                r_hold <= w_rd_word;
            end
        end
    end

endmodule

// File: tb/tb_fir_result_packer.sv
// Bench for fir_result_packer: directed latency/saturation/capacity/reset steps
// plus randomized bursts, checked against a byte-stream scoreboard.
module tb_fir_result_packer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_fir_data;
    logic        i_fir_wren;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        i_byte_ready;
    logic [4:0]  o_count;
    logic        o_full;
    logic        o_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    fir_result_packer dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_fir_data  (i_fir_data),
        .i_fir_wren  (i_fir_wren),
        .o_byte      (o_byte),
        .o_byte_valid(o_byte_valid),
        .i_byte_ready(i_byte_ready),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_overflow  (o_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: round(x / 2^15) with ties toward +inf, clamped to int16.
    function automatic logic [15:0] ref_sample(input logic [31:0] d);
        longint v;
        longint q;
        v = longint'($signed(d));
        q = (v + 64'sd16384) >>> 15;
        if (q > 64'sd32767)  q = 64'sd32767;
        if (q < -64'sd32768) q = -64'sd32768;
        return q[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input logic [31:0] d);
        logic [15:0] s;
        s = ref_sample(d);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
    endtask

    task automatic strobe(input logic [31:0] d);
        i_fir_data = d;
        i_fir_wren = 1'b1;
        enqueue(d);
        tick();
        i_fir_wren = 1'b0;
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        i_byte_ready = 1'b1;
        while ((exp_q.size() != 0 || o_byte_valid !== 1'b0 || o_count !== 5'd0) && k < limit) begin
            tick();
            k++;
        end
        check("drain_done", (exp_q.size() == 0) && (o_byte_valid === 1'b0) && (o_count === 5'd0), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte"},     o_byte,       0);
        check({tag, "_valid"},    o_byte_valid, 0);
        check({tag, "_count"},    o_count,      0);
        check({tag, "_full"},     o_full,       0);
        check({tag, "_overflow"}, o_overflow,   0);
    endtask

    task automatic latency_check(input logic [31:0] d);
        logic [15:0] s;
        s = ref_sample(d);
        i_byte_ready = 1'b1;
        strobe(d);
        check("lat_n0_valid", o_byte_valid, 0);
        tick();
        check("lat_n1_valid", o_byte_valid, 0);
        check("lat_n1_count", o_count, 1);
        tick();
        check("lat_n2_valid", o_byte_valid, 1);
        check("lat_n2_msb", o_byte, s[15:8]);
        tick();
        check("lat_n3_valid", o_byte_valid, 1);
        check("lat_n3_lsb", o_byte, s[7:0]);
        tick();
        check("lat_n4_valid", o_byte_valid, 0);
        check("lat_n4_count", o_count, 0);
    endtask

    // Stream monitor: held bytes stay stable, accepted bytes match the scoreboard.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rst   = 1'b1;
    logic [7:0] prev_byte  = 8'h00;
    always @(negedge clk) begin
        if (!i_rst && !prev_rst && prev_valid && !prev_ready) begin
            check("hold_valid", o_byte_valid, 1);
            check("hold_byte", o_byte, prev_byte);
        end
        if (!i_rst && o_byte_valid === 1'b1 && i_byte_ready) begin
            check("stream_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("stream_byte", o_byte, exp_q.pop_front());
            end
        end
        prev_valid = o_byte_valid;
        prev_ready = i_byte_ready;
        prev_rst   = i_rst;
        prev_byte  = o_byte;
    end

    logic [31:0] sat_vals [5] = '{32'hFFFF_C000, 32'hFFFF_BFFF, 32'h4000_0000,
                                  32'h8000_0000, 32'hC000_0000};

    initial begin
        logic [31:0] d;
        logic [15:0] s;
        i_rst        = 1'b1;
        i_fir_data   = 32'h0;
        i_fir_wren   = 1'b0;
        i_byte_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        i_rst = 1'b0;
        tick();

        latency_check(32'h0000_4000);

        i_byte_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            strobe(sat_vals[i]);
            tick();
            tick();
        end
        drain(100);

        // Stalled sink: 18 back-to-back samples, only FIFO_DEPTH+1 retained.
        i_byte_ready = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            i_fir_data = 32'(j) << 15;
            i_fir_wren = 1'b1;
            if (j <= DEPTH + 1) enqueue(32'(j) << 15);
            tick();
        end
        i_fir_wren = 1'b0;
        check("cap_count", o_count, 16);
        check("cap_full", o_full, 1);
        check("cap_ovf_before", o_overflow, 0);
        check("cap_valid", o_byte_valid, 1);
        check("cap_byte", o_byte, 0);
        tick();
        check("cap_ovf_after", o_overflow, 1);
        check("cap_count_after", o_count, 16);
        drain(200);
        check("cap_ovf_sticky", o_overflow, 1);
        check("cap_full_clear", o_full, 0);

        // Ready toggling every cycle across a 4-word burst.
        for (int i = 0; i < 4; i++) begin
            i_byte_ready = ~i_byte_ready;
            strobe($urandom);
        end
        for (int k = 0; k < 60 && (exp_q.size() != 0 || o_byte_valid); k++) begin
            i_byte_ready = ~i_byte_ready;
            tick();
        end
        drain(50);

        // Randomized bursts small enough never to drop a sample.
        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                d = $urandom;
                d = 32'($signed(d) >>> $urandom_range(0, 20));
                i_byte_ready = 1'($urandom_range(0, 1));
                strobe(d);
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    i_byte_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            drain(300);
        end

        // Reset while the serializer is in LO with 5 words queued.
        i_byte_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strobe($urandom);
        end
        tick();
        tick();
        check("lo_count", o_count, 5);
        i_byte_ready = 1'b1;
        tick();
        i_byte_ready = 1'b0;
        check("lo_valid", o_byte_valid, 1);
        s = {8'h00, exp_q.size() != 0 ? exp_q[0] : 8'hxx};
        check("lo_byte", o_byte, s);
        exp_q.delete();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_reset_outputs("midrst");
        tick();
        latency_check(32'h1234_5678);
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
